// File: rtl/hitbox_scheduler.sv
// Shared collision-checker scheduler: scans all hitbox pairs once per
// frame and publishes the results together as one coherent vector.
module hitbox_scheduler #(
  parameter int N_PAIRS  = 6,
  parameter int COLL_LAT = 1,
  localparam int IDX_W   = $clog2(N_PAIRS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  output logic [IDX_W-1:0]   pair_idx_o,
  output logic               pair_vld_o,
  input  logic               coll_i,
  output logic [N_PAIRS-1:0] colls_o,
  output logic               colls_vld_o,
  output logic               busy_o,
  output logic               overrun_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PAIRS - 1);
  localparam logic [2:0] DRAIN_LAST =
    (COLL_LAT > 0) ? 3'(COLL_LAT - 1) : 3'd0;

  state_t             state;
  logic [2:0]         drain_cnt;
  logic [N_PAIRS-1:0] shadow;
  logic [N_PAIRS-1:0] shadow_nxt;
  logic               samp_vld;
  logic [IDX_W-1:0]   samp_idx;

  // Delay the issued pair by the checker latency so the returning
  // result lands in the bit of the pair that produced it.
  if (COLL_LAT == 0) begin : g_nolat
    assign samp_vld = pair_vld_o;
    assign samp_idx = pair_idx_o;
  end else begin : g_lat
    logic [COLL_LAT-1:0] vld_pipe;
    logic [IDX_W-1:0]    idx_pipe [COLL_LAT];

    // Shift register tracking in-flight checker requests.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        vld_pipe <= '0;
        for (int i = 0; i < COLL_LAT; i++) begin
          idx_pipe[i] <= '0;
        end
      end else begin
        vld_pipe[0] <= pair_vld_o;
        idx_pipe[0] <= pair_idx_o;
        for (int i = 1; i < COLL_LAT; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          idx_pipe[i] <= idx_pipe[i-1];
        end
      end
    end

    assign samp_vld = vld_pipe[COLL_LAT-1];
    assign samp_idx = idx_pipe[COLL_LAT-1];
  end

  // Merge this cycle's checker result so the final sample of a scan
  // can be published on the same edge it is captured.
  always_comb begin
    shadow_nxt = shadow;
    if (samp_vld) begin
      shadow_nxt[samp_idx] = coll_i;
    end
  end

  // Scan sequencer with registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      shadow      <= '0;
      pair_idx_o  <= '0;
      pair_vld_o  <= 1'b0;
      colls_o     <= '0;
      colls_vld_o <= 1'b0;
      busy_o      <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      shadow      <= shadow_nxt;
      colls_vld_o <= 1'b0;
      if (start_i && busy_o) begin
        overrun_o <= 1'b1;
      end
      unique case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state      <= ISSUE;
            pair_idx_o <= '0;
            pair_vld_o <= 1'b1;
            busy_o     <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (pair_idx_o == IDX_LAST) begin
            pair_vld_o <= 1'b0;
            if (COLL_LAT == 0) begin
              state       <= DONE;
              pair_idx_o  <= '0;
              colls_o     <= shadow_nxt;
              colls_vld_o <= 1'b1;
              busy_o      <= 1'b0;
            end else begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            pair_idx_o <= pair_idx_o + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state       <= DONE;
            pair_idx_o  <= '0;
            colls_o     <= shadow_nxt;
            colls_vld_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hitbox_scheduler.sv
// Directed bench for hitbox_scheduler: three builds (latency 0, 1, 3)
// driven side by side, checked every cycle against cycle-count expectations.
module tb_hitbox_scheduler;

  localparam int LATS [3] = '{0, 1, 3};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start [3];
  logic       coll [3];
  logic [2:0] idx [3];
  logic       vld [3];
  logic [5:0] colls [3];
  logic       cv [3];
  logic       busy [3];
  logic       ovr_o [3];

  int         cyc [3];
  logic [5:0] pat [3];
  logic [5:0] shown [3];
  logic       ovr [3];
  logic       ovr_req [3];
  bit         chained [3];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hitbox_scheduler #(.N_PAIRS(6), .COLL_LAT(0)) u_l0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]),
    .pair_idx_o(idx[0]), .pair_vld_o(vld[0]), .coll_i(coll[0]),
    .colls_o(colls[0]), .colls_vld_o(cv[0]), .busy_o(busy[0]),
    .overrun_o(ovr_o[0])
  );

  hitbox_scheduler #(.N_PAIRS(6), .COLL_LAT(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]),
    .pair_idx_o(idx[1]), .pair_vld_o(vld[1]), .coll_i(coll[1]),
    .colls_o(colls[1]), .colls_vld_o(cv[1]), .busy_o(busy[1]),
    .overrun_o(ovr_o[1])
  );

  hitbox_scheduler #(.N_PAIRS(6), .COLL_LAT(3)) u_l3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]),
    .pair_idx_o(idx[2]), .pair_vld_o(vld[2]), .coll_i(coll[2]),
    .colls_o(colls[2]), .colls_vld_o(cv[2]), .busy_o(busy[2]),
    .overrun_o(ovr_o[2])
  );

  // Checker model: pair k answers LAT cycles after it was issued;
  // outside those cycles the line is held high as junk.
  always_comb begin
    for (int d = 0; d < 3; d++) begin
      coll[d] = 1'b1;
      if (cyc[d] >= 1 + LATS[d] && cyc[d] <= 6 + LATS[d]) begin
        coll[d] = pat[d][cyc[d] - 1 - LATS[d]];
      end
    end
  end

  task automatic chk(input string tag, input int d,
                     input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s lat%0d cyc=%0d got=%0h exp=%0h",
               tag, LATS[d], cyc[d], got, exp);
    end
  endtask

  task automatic step();
    bit was_rst;
    @(posedge clk);
    #1;
    was_rst = !rst_n;
    for (int d = 0; d < 3; d++) start[d] = 1'b0;
    if (was_rst) begin
      rst_n = 1'b1;
      for (int d = 0; d < 3; d++) begin
        cyc[d] = 100;
        shown[d] = '0;
        ovr[d] = 1'b0;
        ovr_req[d] = 1'b0;
        chk("rst_idx", d, 32'(idx[d]), 32'd0);
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        cyc[d]++;
        ovr[d] = ovr[d] | ovr_req[d];
        ovr_req[d] = 1'b0;
      end
    end
    for (int d = 0; d < 3; d++) begin
      int l;
      int r;
      bit ev;
      l = LATS[d];
      r = cyc[d];
      if (r == 7 + l) shown[d] = pat[d];
      ev = (r >= 1 && r <= 6);
      chk("vld", d, 32'(vld[d]), 32'(ev));
      if (ev) chk("idx", d, 32'(idx[d]), 32'(r - 1));
      chk("busy", d, 32'(busy[d]), 32'(r >= 1 && r <= 6 + l));
      chk("colls_vld", d, 32'(cv[d]), 32'(r == 7 + l));
      chk("colls", d, 32'(colls[d]), 32'(shown[d]));
      chk("overrun", d, 32'(ovr_o[d]), 32'(ovr[d]));
    end
  endtask

  task automatic go(input int d, input logic [5:0] p);
    start[d] = 1'b1;
    if (cyc[d] >= 1 && cyc[d] <= 6 + LATS[d]) begin
      ovr_req[d] = 1'b1;
    end else begin
      cyc[d] = 0;
      pat[d] = p;
    end
  endtask

  task automatic go_all(input logic [5:0] p);
    for (int d = 0; d < 3; d++) go(d, p);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      cyc[d] = 100;
      pat[d] = '0;
      shown[d] = '0;
      ovr[d] = 1'b0;
      ovr_req[d] = 1'b0;
      chained[d] = 1'b0;
    end
    rst_n = 1'b0;
    step();

    go_all(6'b010001);
    steps(12);

    go_all(6'b000110);
    steps(12);
    go_all(6'b101000);
    steps(12);

    go_all(6'b010101);
    steps(12);

    go_all(6'b100100);
    steps(3);
    go_all(6'b111111);
    steps(9);

    rst_n = 1'b0;
    step();
    steps(2);

    go_all(6'b011000);
    for (int i = 0; i < 22; i++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        if (!chained[d] && cyc[d] == 7 + LATS[d]) begin
          go(d, 6'b100011);
          chained[d] = 1'b1;
        end
      end
    end
    steps(2);

    go_all(6'b110011);
    steps(4);
    rst_n = 1'b0;
    step();
    steps(5);
    go_all(6'b001110);
    steps(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
